row_seq_ctrl: RTL and testbench

ROW_SEQ_CTRL -- requirements
Module: row_seq_ctrl

---
 rtl/row_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_row_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/row_seq_ctrl.sv
// rtl/row_seq_ctrl.sv - job sequencer for a weight-stationary MAC row
//
// Purpose:
//   Runs one job per start request: streams col weight words into the row
//   (KLOAD), lets the load wavefront reach the last tile (KWAIT), issues len
//   activation vectors (EXEC), waits for every result to leave the last tile
//   (DRAIN) and signals completion (DONE).
//
// Ports:
//   clk        in   1        sole clock, rising edge
//   reset      in   1        asynchronous, active-high
//   start      in   1        job request, sampled only in IDLE
//   mode       in   1        1 = 4-bit, 0 = 2-bit; captured on accepted start
//   len        in   cnt_bw   execute vector count; captured on accepted start
//   w_avail    in   1        weight source holds a valid word
//   act_avail  in   1        activation source holds a valid word
//   row_valid  in   col      per-tile valid bits from the MAC row
//   w_rd       out  1        weight pop strobe
//   act_rd     out  1        activation pop strobe
//   inst_w     out  inst_bw  row instruction: [2] mode, [1] exec, [0] kload
//   psum_wr    out  1        output psum buffer write strobe
//   busy       out  1        state is not IDLE
//   done       out  1        one-cycle job-complete pulse

module row_seq_ctrl #(
  parameter int col     = 8,
  parameter int inst_bw = 3,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [cnt_bw-1:0]  len,
  input  logic               w_avail,
  input  logic               act_avail,
  input  logic [col-1:0]     row_valid,
  output logic               w_rd,
  output logic               act_rd,
  output logic [inst_bw-1:0] inst_w,
  output logic               psum_wr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_KWAIT,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [cnt_bw-1:0] LP_ONE       = cnt_bw'(1);
  localparam logic [cnt_bw-1:0] LP_LAST_TILE = cnt_bw'(col - 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_mode_q;
  logic [cnt_bw-1:0] r_len_q;
  logic [cnt_bw-1:0] r_ld_cnt;   // weight loads issued
  logic [cnt_bw-1:0] r_wt_cnt;   // cycles spent in KWAIT
  logic [cnt_bw-1:0] r_tx_cnt;   // execute vectors issued
  logic [cnt_bw-1:0] r_rx_cnt;   // results written to the psum buffer

  logic [2:0]        w_inst;
  logic              w_busy;
  logic              w_psum;
  logic [cnt_bw:0]   w_rx_sum;
  logic              w_rx_done;
  logic              w_unused_rv;

  // Only the last tile's valid bit marks a finished result; the other
  // tiles' bits are part of the row interface but carry no meaning here.
  assign w_unused_rv = ^row_valid[col-2:0];

  assign w_busy = (r_state != S_IDLE);

  // Results are only counted while a job is live. DONE is excluded so the
  // completion cycle keeps every strobe quiet.
  assign w_psum = row_valid[col-1] & w_busy & (r_state != S_DONE);

  // One extra bit so a same-cycle increment at the top of the counter range
  // still compares correctly against len_q.
  assign w_rx_sum  = {1'b0, r_rx_cnt} + {{cnt_bw{1'b0}}, w_psum};
  assign w_rx_done = (w_rx_sum >= {1'b0, r_len_q});

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    act_rd      = 1'b0;
    w_inst      = 3'b000;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_KLOAD;
        end
      end

      S_KLOAD: begin
        // A cycle without a weight word is a bubble: no kload, no pop.
        w_rd   = w_avail;
        w_inst = {r_mode_q, 1'b0, w_avail};
        if (w_avail && (r_ld_cnt == LP_LAST_TILE)) begin
          w_state_nxt = S_KWAIT;
        end
      end

      S_KWAIT: begin
        w_inst = {r_mode_q, 2'b00};
        if (r_wt_cnt == LP_LAST_TILE) begin
          w_state_nxt = (r_len_q != '0) ? S_EXEC : S_DONE;
        end
      end

      S_EXEC: begin
        // EXEC is only entered with len_q != 0, so len_q - 1 cannot wrap.
        act_rd = act_avail;
        w_inst = {r_mode_q, act_avail, 1'b0};
        if (act_avail && (r_tx_cnt == (r_len_q - LP_ONE))) begin
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        w_inst = {r_mode_q, 2'b00};
        if (w_rx_done) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_inst      = {r_mode_q, 2'b00};
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    inst_w      = '0;
    inst_w[2:0] = w_inst;
  end

  assign psum_wr = w_psum;
  assign busy    = w_busy;

  // Job parameters and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_q <= 1'b0;
      r_len_q  <= '0;
      r_ld_cnt <= '0;
      r_wt_cnt <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      // mode/len are only looked at here, so changes mid-job are harmless.
      if (start) begin
        r_mode_q <= mode;
        r_len_q  <= len;
        r_ld_cnt <= '0;
        r_wt_cnt <= '0;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
      end
    end else begin
      if (w_rd) begin
        r_ld_cnt <= r_ld_cnt + LP_ONE;
      end
      if (r_state == S_KWAIT) begin
        r_wt_cnt <= r_wt_cnt + LP_ONE;
      end
      if (act_rd) begin
        r_tx_cnt <= r_tx_cnt + LP_ONE;
      end
      if (w_psum) begin
        r_rx_cnt <= r_rx_cnt + LP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_row_seq_ctrl.sv
// tb/tb_row_seq_ctrl.sv - self-checking bench for row_seq_ctrl

module tb_row_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] len;
  logic       w_avail;
  logic       act_avail;
  logic [7:0] row_valid;
  logic       w_rd;
  logic       act_rd;
  logic [2:0] inst_w;
  logic       psum_wr;
  logic       busy;
  logic       done;
  logic [7:0] outv;

  row_seq_ctrl #(.col(8), .inst_bw(3), .cnt_bw(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .w_avail   (w_avail),
    .act_avail (act_avail),
    .row_valid (row_valid),
    .w_rd      (w_rd),
    .act_rd    (act_rd),
    .inst_w    (inst_w),
    .psum_wr   (psum_wr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign outv = {w_rd, act_rd, inst_w, psum_wr, busy, done};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Nominal job: len=4, mode=1, both sources always available, last-tile
  // valid 8 cycles after each exec. Expected = {w_rd,act_rd,inst_w,psum_wr,busy,done}.
  typedef struct {
    logic       start;
    logic       rv7;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[31];

  task automatic apply_table(input string tag);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      start     = tbl[k].start;
      mode      = 1'b1;
      len       = 8'd4;
      w_avail   = 1'b1;
      act_avail = 1'b1;
      row_valid = {tbl[k].rv7, 7'b0};
      #1;
      chk($sformatf("%s_v%0d", tag, k), int'(outv), int'(tbl[k].exp));
    end
    start = 1'b0;
  endtask

  // Runs one job with a modelled MAC row (8-cycle exec-to-last-tile delay).
  // Index t = 0 is the first cycle after start is accepted.
  task automatic run_job(input logic m, input logic [7:0] l, input bit tog, input bit poke,
                         output int n_w, output int n_a, output int n_p,
                         output int last_w, output int t_done, output int bad);
    logic [7:0] pipe;
    int         kl;
    logic       exp_w;
    pipe = '0; n_w = 0; n_a = 0; n_p = 0; last_w = -1; t_done = -1; bad = 0;
    kl = tog ? 15 : 8;
    @(negedge clk);
    start = 1'b1; mode = m; len = l;
    w_avail = 1'b0; act_avail = 1'b0; row_valid = '0;
    for (int t = 0; t < 600 && t_done < 0; t++) begin
      @(negedge clk);
      w_avail   = tog ? ~t[0] : 1'b1;
      act_avail = 1'b1;
      row_valid = {pipe[7], 7'b0};
      start     = poke && (t == 10);
      mode      = (poke && t >= 10) ? ~m : m;
      len       = (poke && t >= 10) ? 8'd9 : l;
      #1;
      exp_w = (t < kl) ? w_avail : 1'b0;
      if (w_rd !== exp_w || inst_w[0] !== exp_w) bad++;
      if (busy && inst_w[2] !== m) bad++;
      if (w_rd) begin n_w++; last_w = t; end
      if (act_rd) n_a++;
      if (psum_wr) n_p++;
      if (done) t_done = t;
      pipe = {pipe[6:0], act_rd};
    end
    start = 1'b0; w_avail = 1'b0; act_avail = 1'b0; row_valid = '0;
    @(negedge clk);
  endtask

  int n_w, n_a, n_p, last_w, t_done, bad;

  initial begin
    for (int k = 0; k < 31; k++) begin
      tbl[k].start = (k == 0);
      tbl[k].rv7   = (k >= 25 && k <= 28);
      if (k == 0 || k == 30)      tbl[k].exp = 8'b0000_0000;
      else if (k <= 8)            tbl[k].exp = 8'b1010_1010;
      else if (k <= 16)           tbl[k].exp = 8'b0010_0010;
      else if (k <= 20)           tbl[k].exp = 8'b0111_0010;
      else if (k <= 24)           tbl[k].exp = 8'b0010_0010;
      else if (k <= 28)           tbl[k].exp = 8'b0010_0110;
      else                        tbl[k].exp = 8'b0010_0011;
    end

    reset = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
    w_avail = 1'b0; act_avail = 1'b0; row_valid = '0;
    @(negedge clk);
    #1;
    chk("reset_outs", int'(outv), 0);
    chk("reset_rxcnt", int'(dut.r_rx_cnt), 0);
    reset = 1'b0;

    apply_table("nominal");

    // Weight back-pressure
    run_job(1'b0, 8'd1, 1'b1, 1'b0, n_w, n_a, n_p, last_w, t_done, bad);
    chk("bp_w_pulses", n_w, 8);
    chk("bp_kload_len", last_w + 1, 15);
    chk("bp_follow", bad, 0);
    chk("bp_act", n_a, 1);
    chk("bp_psum", n_p, 1);
    chk("bp_done_t", t_done, 32);

    // Zero-length job
    run_job(1'b1, 8'd0, 1'b0, 1'b0, n_w, n_a, n_p, last_w, t_done, bad);
    chk("len0_w", n_w, 8);
    chk("len0_act", n_a, 0);
    chk("len0_psum", n_p, 0);
    chk("len0_done_t", t_done, 16);
    chk("len0_follow", bad, 0);

    // Maximum length
    run_job(1'b0, 8'd255, 1'b0, 1'b0, n_w, n_a, n_p, last_w, t_done, bad);
    chk("max_act", n_a, 255);
    chk("max_psum", n_p, 255);
    chk("max_done_t", t_done, 279);

    // start/mode/len poked mid-job, then row_valid in IDLE
    run_job(1'b1, 8'd2, 1'b0, 1'b1, n_w, n_a, n_p, last_w, t_done, bad);
    chk("poke_act", n_a, 2);
    chk("poke_psum", n_p, 2);
    chk("poke_done_t", t_done, 26);
    chk("poke_mode", bad, 0);
    chk("poke_rxcnt", int'(dut.r_rx_cnt), 2);
    row_valid = 8'h80;
    #1;
    chk("idle_rv_psum", int'(psum_wr), 0);
    chk("idle_rv_busy", int'(busy), 0);
    @(negedge clk);
    row_valid = '0;
    #1;
    chk("idle_rv_rxcnt", int'(dut.r_rx_cnt), 2);
    chk("idle_rv_busy2", int'(busy), 0);

    // Asynchronous reset in the middle of EXEC
    @(negedge clk);
    start = 1'b1; mode = 1'b1; len = 8'd4; w_avail = 1'b1; act_avail = 1'b1; row_valid = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    chk("exec_pre_rst", int'(outv), 8'b0111_0010);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_outs", int'(outv), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_outs", int'(outv), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_busy%0d", i), int'(busy), 0);
    end
    apply_table("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
